fp_op_dispatcher: RTL and testbench
===================================

Name: fp_op_dispatcher

Overview:
Operand issue and result collection stage for the floating_point_adder / floating_point_multiply IP pair. It buffers {op, a, b} requests and drives the IPs' s_axis_a/s_axis_b channels with correct per-channel AXI-stream handshakes. It then merges both m_axis_result streams back into one in-order result stream. The IPs are configured in blocking mode (tready used) and share this block's clk and reset.

Parameters:
DEPTH, 8, operand FIFO entries (power of 2, >=2)
TAGS, 16, max issued-but-unreturned operations; tag FIFO depth (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_op  in  1  0 = add, 1 = multiply
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B, IEEE-754 single
op_a_tdata  out  32  A data, shared by both IPs' s_axis_a_tdata
op_b_tdata  out  32  B data, shared by both IPs' s_axis_b_tdata
add_a_tvalid / add_b_tvalid  out  1 each  adder s_axis_a/b_tvalid
add_a_tready / add_b_tready  in  1 each  adder s_axis_a/b_tready
mul_a_tvalid / mul_b_tvalid  out  1 each  multiplier s_axis_a/b_tvalid
mul_a_tready / mul_b_tready  in  1 each  multiplier s_axis_a/b_tready
add_res_tvalid  in  1  adder m_axis_result_tvalid
add_res_tdata  in  32  adder m_axis_result_tdata
add_res_tready  out  1  adder m_axis_result_tready
mul_res_tvalid  in  1  multiplier m_axis_result_tvalid
mul_res_tdata  in  32  multiplier m_axis_result_tdata
mul_res_tready  out  1  multiplier m_axis_result_tready
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  32  result
out_op  out  1  op that produced out_data

Behaviour:
- Reset (synchronous): FIFO pointers, tag FIFO, a_taken/b_taken flags, and out_valid/out_data/out_op cleared to 0; all tvalid/tready outputs 0. in_ready = !full && !reset. Reset mid-operation discards queued requests and outstanding tags; the IPs are reset by the same signal.
- Operand FIFO: push on in handshake. No bypass: an entry accepted into an empty FIFO is presented to the IP starting the next cycle (min latency 1). in_ready is low while full.
- Issue: the head entry selects the IP by op; the other IP's tvalids are 0. op_a/b_tdata = head a/b, held stable until pop.
- Issue gating: x_tvalid = !empty && !x_taken && (tag_count<TAGS || a_taken || b_taken). A new issue does not start while the tag FIFO is full.
- Channel handshakes: a handshake on channel A sets a_taken and drops A's tvalid next cycle; B is independent. Pop occurs on the cycle the second channel completes (both in the same cycle is allowed). On pop: clear both flags, push op into the tag FIFO, and advance the head. Back-to-back issue at 1 op/cycle when readys are high.
- Collection: results are returned strictly in issue order. add_res_tready = tag_nonempty && tag_head==0 && (!out_valid || out_ready); mul_res_tready is the same with tag_head==1. A result from the non-head IP waits with tready low.
- On a result handshake: pop the tag; out_data/out_op load and out_valid=1 on the next edge (1-cycle latency). out_valid stays high, with data stable, until out_ready. Simultaneous out handshake and new result give continuous streaming.
- Simultaneous push and pop allowed in both FIFOs at any occupancy except push-when-full, which is blocked by the ready logic.

Test Plan:
- Single add: push op=0, a=45bf70fc, b=40998b1a, all readys 1 -> add_a/b_tvalid high exactly 1 cycle, starting 1 cycle after accept, with op_a/b_tdata=45bf70fc/40998b1a; mul_*_tvalid stay 0. Adder model returns 0x45c0...-style value X -> out_valid one cycle after, out_data=X, out_op=0.
- Split ready: mul op, mul_a_tready=1, mul_b_tready=0 for 3 cycles -> mul_a_tvalid high 1 cycle only; mul_b_tvalid held 4 cycles with stable data; pop and tag push on the B handshake.
- Ordering: push add, mul, add; mul model returns first -> mul_res_tready=0 until the first add result is consumed; out_op sequence 0,1,0 with matching data.
- Full/limits: all IP readys 0, push 9 requests -> in_ready drops after the 8th accept. With result readys blocked, TAGS=16 ops issued -> the 17th is not issued until one result is consumed.
- Backpressure: out_ready=0 with out_valid=1 -> both res_treadys 0 and out_data stable. out_ready=1 -> next result streams with no bubble.
- Reset mid-run: 3 queued, 1 in flight, reset high 1 cycle -> next cycle all tvalids/treadys/out_valid=0. in_ready=1 the cycle after release, and no stale result appears.

Source files
------------

// File: rtl/fp_op_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : fp_op_dispatcher
// Function : Buffers {op,a,b} requests, issues them to the FP adder/multiplier
//            AXI-stream operand channels, and merges results back in order.
// Revision : 1.0  initial release
// ============================================================================
module fp_op_dispatcher #(
    parameter int DEPTH = 8,
    parameter int TAGS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] op_a_tdata,
    output logic [31:0] op_b_tdata,
    output logic        add_a_tvalid,
    output logic        add_b_tvalid,
    input  logic        add_a_tready,
    input  logic        add_b_tready,
    output logic        mul_a_tvalid,
    output logic        mul_b_tvalid,
    input  logic        mul_a_tready,
    input  logic        mul_b_tready,
    input  logic        add_res_tvalid,
    input  logic [31:0] add_res_tdata,
    output logic        add_res_tready,
    input  logic        mul_res_tvalid,
    input  logic [31:0] mul_res_tdata,
    output logic        mul_res_tready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_op
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_TW = $clog2(TAGS);
    localparam logic [c_AW-1:0] c_APTR_ONE  = {{(c_AW-1){1'b0}}, 1'b1};
    localparam logic [c_AW:0]   c_ACNT_ONE  = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW:0]   c_DEPTH_CNT = DEPTH[c_AW:0];
    localparam logic [c_TW-1:0] c_TPTR_ONE  = {{(c_TW-1){1'b0}}, 1'b1};
    localparam logic [c_TW:0]   c_TCNT_ONE  = {{c_TW{1'b0}}, 1'b1};
    localparam logic [c_TW:0]   c_TAGS_CNT  = TAGS[c_TW:0];

    // Operand FIFO storage: {op, a, b}
    logic [64:0]     r_op_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_op_cnt;
    logic            r_tag_mem [TAGS];
    logic [c_TW-1:0] r_tag_wr, r_tag_rd;
    logic [c_TW:0]   r_tag_cnt;
    logic            r_a_taken, r_b_taken;
    logic            r_out_valid, r_out_op;
    logic [31:0]     r_out_data;

    logic [64:0] w_head;
    logic        w_head_op, w_op_empty, w_op_full, w_tag_full, w_tag_nonempty, w_tag_head;
    logic        w_in_hs, w_issue_ok, w_a_valid, w_b_valid, w_a_hs, w_b_hs, w_issue_pop;
    logic        w_out_free, w_res_hs;

    assign w_head         = r_op_mem[r_rd_ptr];
    assign w_head_op      = w_head[64];
    assign w_op_empty     = (r_op_cnt == '0);
    assign w_op_full      = (r_op_cnt == c_DEPTH_CNT);
    assign w_tag_full     = (r_tag_cnt == c_TAGS_CNT);
    assign w_tag_nonempty = (r_tag_cnt != '0);
    assign w_tag_head     = r_tag_mem[r_tag_rd];

    assign in_ready = !w_op_full && !reset;
    assign w_in_hs  = in_valid && in_ready;

    // Once one channel of an op has gone out, the other must be allowed to
    // finish even when the tag FIFO is full, otherwise the pair would deadlock.
    assign w_issue_ok  = !reset && !w_op_empty && (!w_tag_full || r_a_taken || r_b_taken);
    assign w_a_valid   = w_issue_ok && !r_a_taken;
    assign w_b_valid   = w_issue_ok && !r_b_taken;
    assign w_a_hs      = w_a_valid && (w_head_op ? mul_a_tready : add_a_tready);
    assign w_b_hs      = w_b_valid && (w_head_op ? mul_b_tready : add_b_tready);
    assign w_issue_pop = (r_a_taken || w_a_hs) && (r_b_taken || w_b_hs);

    assign add_a_tvalid = w_a_valid && !w_head_op;
    assign add_b_tvalid = w_b_valid && !w_head_op;
    assign mul_a_tvalid = w_a_valid && w_head_op;
    assign mul_b_tvalid = w_b_valid && w_head_op;
    assign op_a_tdata   = w_head[63:32];
    assign op_b_tdata   = w_head[31:0];

    assign w_out_free     = !r_out_valid || out_ready;
    assign add_res_tready = !reset && w_tag_nonempty && !w_tag_head && w_out_free;
    assign mul_res_tready = !reset && w_tag_nonempty && w_tag_head && w_out_free;
    assign w_res_hs       = (add_res_tvalid && add_res_tready) ||
                            (mul_res_tvalid && mul_res_tready);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_op    = r_out_op;

    always_ff @(posedge clk) begin
        if (w_in_hs) r_op_mem[r_wr_ptr] <= {in_op, in_a, in_b};
        if (w_issue_pop) r_tag_mem[r_tag_wr] <= w_head_op;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_op_cnt  <= '0;
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
            r_a_taken <= 1'b0;
            r_b_taken <= 1'b0;
        end else begin
            if (w_in_hs) r_wr_ptr <= r_wr_ptr + c_APTR_ONE;
            if (w_issue_pop) r_rd_ptr <= r_rd_ptr + c_APTR_ONE;
            case ({w_in_hs, w_issue_pop})
                2'b10:   r_op_cnt <= r_op_cnt + c_ACNT_ONE;
                2'b01:   r_op_cnt <= r_op_cnt - c_ACNT_ONE;
                default: ;
            endcase

            if (w_issue_pop) r_tag_wr <= r_tag_wr + c_TPTR_ONE;
            if (w_res_hs) r_tag_rd <= r_tag_rd + c_TPTR_ONE;
            case ({w_issue_pop, w_res_hs})
                2'b10:   r_tag_cnt <= r_tag_cnt + c_TCNT_ONE;
                2'b01:   r_tag_cnt <= r_tag_cnt - c_TCNT_ONE;
                default: ;
            endcase

            if (w_issue_pop) begin
                r_a_taken <= 1'b0;
                r_b_taken <= 1'b0;
            end else begin
                if (w_a_hs) r_a_taken <= 1'b1;
                if (w_b_hs) r_b_taken <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_op    <= 1'b0;
        end else if (w_res_hs) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_tag_head ? mul_res_tdata : add_res_tdata;
            r_out_op    <= w_tag_head;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_op_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_op_dispatcher
// Function : Directed + randomized bench with behavioural adder/multiplier
//            stand-ins and an in-order result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_op_dispatcher;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_op;
    logic [31:0] in_a, in_b, op_a_tdata, op_b_tdata;
    logic        add_a_tvalid, add_b_tvalid, add_a_tready, add_b_tready;
    logic        mul_a_tvalid, mul_b_tvalid, mul_a_tready, mul_b_tready;
    logic        add_res_tvalid, add_res_tready, mul_res_tvalid, mul_res_tready;
    logic [31:0] add_res_tdata, mul_res_tdata, out_data;
    logic        out_valid, out_ready, out_op;

    always #5 clk = ~clk;

    fp_op_dispatcher #(.DEPTH(8), .TAGS(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .op_a_tdata(op_a_tdata), .op_b_tdata(op_b_tdata),
        .add_a_tvalid(add_a_tvalid), .add_b_tvalid(add_b_tvalid),
        .add_a_tready(add_a_tready), .add_b_tready(add_b_tready),
        .mul_a_tvalid(mul_a_tvalid), .mul_b_tvalid(mul_b_tvalid),
        .mul_a_tready(mul_a_tready), .mul_b_tready(mul_b_tready),
        .add_res_tvalid(add_res_tvalid), .add_res_tdata(add_res_tdata),
        .add_res_tready(add_res_tready),
        .mul_res_tvalid(mul_res_tvalid), .mul_res_tdata(mul_res_tdata),
        .mul_res_tready(mul_res_tready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic stand-ins: the dispatcher never looks at values, so plain
    // integer add/multiply is enough to tell results apart.
    function automatic logic [31:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
        return op ? a * b : a + b;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    logic [32:0] exp_q[$];
    logic [31:0] add_qa[$], add_qb[$], mul_qa[$], mul_qb[$], add_rq[$], mul_rq[$];
    logic        out_log[$];
    int          rdy_pct[4];
    int          res_pct[2];
    int          in_pct, out_pct;
    bit          auto_in, rst_req, req_v, last_acc, in_hold, add_r_hold, mul_r_hold, po_hold;
    logic        req_op;
    logic [31:0] req_a, req_b, pa_data, pb_data;
    logic [32:0] po_val;
    logic [3:0]  pa_hold;
    int          n_issued;

    task automatic set_pct(input int rdy, input int res, input int outp);
        for (int i = 0; i < 4; i++) rdy_pct[i] = rdy;
        res_pct[0] = res;
        res_pct[1] = res;
        out_pct    = outp;
    endtask

    task automatic clear_model();
        exp_q.delete(); add_qa.delete(); add_qb.delete(); mul_qa.delete(); mul_qb.delete();
        add_rq.delete(); mul_rq.delete();
        in_hold = 0; add_r_hold = 0; mul_r_hold = 0; po_hold = 0; pa_hold = '0; last_acc = 0;
    endtask

    task automatic observe();
        logic [3:0] tv, tr;
        tv = {mul_b_tvalid, mul_a_tvalid, add_b_tvalid, add_a_tvalid};
        tr = {mul_b_tready, mul_a_tready, add_b_tready, add_a_tready};
        last_acc = in_valid && in_ready;
        if (last_acc) exp_q.push_back({in_op, ref_result(in_op, in_a, in_b)});
        in_hold = in_valid && !in_ready;

        for (int i = 0; i < 4; i++)
            if (pa_hold[i]) check_eq($sformatf("tvalid_hold%0d", i), tv[i], 1);
        if (pa_hold[0] || pa_hold[2]) check_eq("op_a_stable", op_a_tdata, pa_data);
        if (pa_hold[1] || pa_hold[3]) check_eq("op_b_stable", op_b_tdata, pb_data);
        if (tv[0] || tv[1]) check_eq("ip_exclusive", tv[2] | tv[3], 0);
        pa_hold = tv & ~tr;
        pa_data = op_a_tdata;
        pb_data = op_b_tdata;

        if (tv[0] && tr[0]) add_qa.push_back(op_a_tdata);
        if (tv[1] && tr[1]) add_qb.push_back(op_b_tdata);
        if (tv[2] && tr[2]) mul_qa.push_back(op_a_tdata);
        if (tv[3] && tr[3]) mul_qb.push_back(op_b_tdata);
        while (add_qa.size() > 0 && add_qb.size() > 0) begin
            add_rq.push_back(add_qa.pop_front() + add_qb.pop_front());
            n_issued++;
        end
        while (mul_qa.size() > 0 && mul_qb.size() > 0) begin
            mul_rq.push_back(mul_qa.pop_front() * mul_qb.pop_front());
            n_issued++;
        end

        if (add_res_tvalid && add_res_tready) void'(add_rq.pop_front());
        if (mul_res_tvalid && mul_res_tready) void'(mul_rq.pop_front());
        add_r_hold = add_res_tvalid && !add_res_tready;
        mul_r_hold = mul_res_tvalid && !mul_res_tready;

        if (out_valid && !out_ready)
            check_eq("res_tready_backpressure", {add_res_tready, mul_res_tready}, 0);
        if (po_hold) begin
            check_eq("out_valid_hold", out_valid, 1);
            check_eq("out_stable", {out_op, out_data}, po_val);
        end
        po_hold = out_valid && !out_ready;
        po_val  = {out_op, out_data};
        if (out_valid && out_ready) begin
            check_eq("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("out_result", {out_op, out_data}, exp_q.pop_front());
            out_log.push_back(out_op);
        end
    endtask

    task automatic step();
        @(negedge clk);
        reset = rst_req;
        if (!auto_in) begin
            in_valid = req_v; in_op = req_op; in_a = req_a; in_b = req_b;
        end else if (!in_hold) begin
            in_valid = roll(in_pct);
            in_op = 1'($urandom_range(1)); in_a = $urandom; in_b = $urandom;
        end
        add_a_tready = roll(rdy_pct[0]);
        add_b_tready = roll(rdy_pct[1]);
        mul_a_tready = roll(rdy_pct[2]);
        mul_b_tready = roll(rdy_pct[3]);
        add_res_tvalid = (add_rq.size() > 0) && (add_r_hold || roll(res_pct[0]));
        add_res_tdata  = (add_rq.size() > 0) ? add_rq[0] : 32'h0;
        mul_res_tvalid = (mul_rq.size() > 0) && (mul_r_hold || roll(res_pct[1]));
        mul_res_tdata  = (mul_rq.size() > 0) ? mul_rq[0] : 32'h0;
        out_ready = roll(out_pct);
        #1;
        if (reset) clear_model();
        else observe();
    endtask

    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b);
        req_v = 1; req_op = op; req_a = a; req_b = b;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) break;
        end
        req_v = 0;
        check_eq("send_accepted", last_acc, 1);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) step();
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base, acc;
        reset = 1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0;
        add_a_tready = 0; add_b_tready = 0; mul_a_tready = 0; mul_b_tready = 0;
        add_res_tvalid = 0; add_res_tdata = 0; mul_res_tvalid = 0; mul_res_tdata = 0;
        out_ready = 0;
        auto_in = 0; req_v = 0; req_op = 0; req_a = 0; req_b = 0; in_pct = 0;
        n_issued = 0; pa_data = 0; pb_data = 0; po_val = 0;
        set_pct(100, 100, 100);
        clear_model();

        // Reset state
        rst_req = 1; step(); step(); rst_req = 0; step();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_tvalids", {add_a_tvalid, add_b_tvalid, mul_a_tvalid, mul_b_tvalid}, 0);
        check_eq("rst_res_treadys", {add_res_tready, mul_res_tready}, 0);

        // Single add, minimum latency
        send(0, 32'h45bf70fc, 32'h40998b1a);
        step();
        check_eq("t1_add_tvalids", {add_a_tvalid, add_b_tvalid}, 2'b11);
        check_eq("t1_op_a", op_a_tdata, 32'h45bf70fc);
        check_eq("t1_op_b", op_b_tdata, 32'h40998b1a);
        check_eq("t1_mul_tvalids", {mul_a_tvalid, mul_b_tvalid}, 0);
        step();
        check_eq("t1_add_once", {add_a_tvalid, add_b_tvalid}, 0);
        step();
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_out", {out_op, out_data}, {1'b0, 32'h8658fc16});
        drain(50);

        // Split ready on the multiplier
        rdy_pct = '{100, 100, 100, 0};
        send(1, 32'h3fc00000, 32'h40200000);
        base = n_issued;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t2_b_held", mul_b_tvalid, 1);
            check_eq("t2_a_once", mul_a_tvalid, i == 0);
        end
        rdy_pct[3] = 100;
        step();
        check_eq("t2_b_4th", {mul_a_tvalid, mul_b_tvalid}, 2'b01);
        check_eq("t2_issued", n_issued - base, 1);
        step();
        check_eq("t2_b_drop", mul_b_tvalid, 0);
        drain(50);

        // Ordering: multiplier result arrives first but must wait
        out_log.delete();
        res_pct = '{0, 100};
        send(0, 32'h11111111, 32'h22222222);
        send(1, 32'h00000003, 32'h00000005);
        send(0, 32'h0000000a, 32'h00000014);
        for (int i = 0; i < 6; i++) begin
            step();
            if (mul_res_tvalid) check_eq("t3_mul_waits", mul_res_tready, 0);
        end
        check_eq("t3_out_idle", out_valid, 0);
        res_pct[0] = 100;
        drain(50);
        check_eq("t3_order", {out_log.size(), out_log[0], out_log[1], out_log[2]}, {32'd3, 3'b010});

        // Operand FIFO full
        set_pct(0, 100, 100);
        acc = 0; req_v = 1; req_op = 0; req_a = $urandom; req_b = $urandom;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_acc) begin
                acc++; req_op = 1'($urandom_range(1)); req_a = $urandom; req_b = $urandom;
            end
        end
        req_v = 0;
        check_eq("t4_accepts", acc, 8);
        check_eq("t4_in_ready_full", in_ready, 0);
        set_pct(100, 100, 100);
        drain(100);

        // Tag limit
        set_pct(100, 0, 100);
        base = n_issued; acc = 0;
        req_v = 1; req_op = 0; req_a = $urandom; req_b = $urandom;
        for (int i = 0; i < 100 && acc < 17; i++) begin
            step();
            if (last_acc) begin
                acc++; req_op = 1'($urandom_range(1)); req_a = $urandom; req_b = $urandom;
            end
        end
        req_v = 0;
        for (int i = 0; i < 10; i++) step();
        check_eq("t4_tag_issued", n_issued - base, 16);
        check_eq("t4_tag_stall", {add_a_tvalid, add_b_tvalid, mul_a_tvalid, mul_b_tvalid}, 0);
        set_pct(100, 100, 100);
        drain(200);
        check_eq("t4_tag_all", n_issued - base, 17);

        // Output backpressure then bubble-free streaming
        set_pct(100, 100, 0);
        send(0, 32'h1, 32'h2);
        send(1, 32'h3, 32'h4);
        send(0, 32'h5, 32'h6);
        for (int i = 0; i < 8; i++) step();
        check_eq("t5_out_valid", out_valid, 1);
        out_pct = 100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5_stream", out_valid, 1);
        end
        drain(50);

        // Reset mid-run: one op half-issued, three queued
        rdy_pct = '{100, 100, 100, 0};
        send(1, 32'h7, 32'h9);
        step();
        send(0, 32'h1, 32'h1);
        send(0, 32'h2, 32'h2);
        send(1, 32'h3, 32'h3);
        rst_req = 1; step(); rst_req = 0; step();
        check_eq("t6_tvalids", {add_a_tvalid, add_b_tvalid, mul_a_tvalid, mul_b_tvalid}, 0);
        check_eq("t6_treadys", {add_res_tready, mul_res_tready}, 0);
        check_eq("t6_out_valid", out_valid, 0);
        check_eq("t6_in_ready", in_ready, 1);

        // Randomized traffic
        auto_in = 1;
        for (int ph = 0; ph < 4; ph++) begin
            in_pct = 30 + 20 * ph;
            for (int i = 0; i < 4; i++) rdy_pct[i] = 40 + int'($urandom_range(60));
            res_pct = '{30 + int'($urandom_range(70)), 30 + int'($urandom_range(70))};
            out_pct = 30 + int'($urandom_range(70));
            for (int i = 0; i < 1500; i++) step();
        end
        auto_in = 0;
        set_pct(100, 100, 100);
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
